// File: rtl/pin_route_if.sv
// Command handshake bundle for pin_route_ctrl: a valid/ready channel carrying
// an opcode plus destination and source pin indices.
interface pin_route_if #(
    parameter int SEL_W = 6,
    parameter int DST_W = 5
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [DST_W-1:0] cmd_dst;
    logic [SEL_W-1:0] cmd_src;

    modport master (output cmd_valid, cmd_op, cmd_dst, cmd_src, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_dst, cmd_src, output cmd_ready);
endinterface

// File: rtl/pin_route_ctrl.sv
// Shadow/active pin crossbar with break-before-make commit sequencing.
// Optional macro PIN_ROUTE_CONFLICT_CHECK_EN rejects SETs that would fan a source out.
module pin_route_ctrl #(
    parameter int N_SRC     = 36,
    parameter int N_DST     = 21,
    parameter int SEL_W     = 6,
    parameter int DST_W     = 5,
    parameter int GUARD_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pin_route_if.slave        cmd,
    input  logic [N_SRC-1:0]  src_in,
    output logic [N_DST-1:0]  dst_out,
    output logic [N_DST-1:0]  dst_oe,
    output logic              busy,
    output logic              err
);
    localparam int CNT_W = $clog2(GUARD_CYC + 1);

    localparam logic [1:0] OP_SET       = 2'd0;
    localparam logic [1:0] OP_CLEAR     = 2'd1;
    localparam logic [1:0] OP_COMMIT    = 2'd2;
    localparam logic [1:0] OP_CLEAR_ALL = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_MAKE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_DST-1:0]   shadow_en_q, shadow_en_d;
    logic [SEL_W-1:0]   shadow_sel_q [N_DST];
    logic [SEL_W-1:0]   shadow_sel_d [N_DST];
    logic [N_DST-1:0]   active_en_q, active_en_d;
    logic [SEL_W-1:0]   active_sel_q [N_DST];
    logic [SEL_W-1:0]   active_sel_d [N_DST];
    logic [N_DST-1:0]   dst_out_q, dst_out_d;
    logic [N_DST-1:0]   dst_oe_q, dst_oe_d;
    logic               err_q, err_d;

    logic accept, dst_bad, src_bad, conflict, reject;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && cmd.cmd_op == OP_COMMIT) state_d = ST_BREAK;
            ST_BREAK: if (cnt_q == CNT_W'(GUARD_CYC - 1)) state_d = ST_MAKE;
            ST_MAKE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cmd.cmd_ready = (state_q == ST_IDLE);
        busy          = (state_q != ST_IDLE);
    end

    // ---------------- command decode ----------------
    assign accept  = cmd.cmd_valid && cmd.cmd_ready;
    assign dst_bad = 32'(cmd.cmd_dst) >= N_DST;
    assign src_bad = 32'(cmd.cmd_src) >= N_SRC;

    always_comb begin
        conflict = 1'b0;
`ifdef PIN_ROUTE_CONFLICT_CHECK_EN
        for (int d = 0; d < N_DST; d++) begin
            if (shadow_en_q[d] && shadow_sel_q[d] == cmd.cmd_src &&
                DST_W'(d) != cmd.cmd_dst)
                conflict = 1'b1;
        end
`endif
    end

    assign reject = accept &&
                    (((cmd.cmd_op == OP_SET) && (dst_bad || src_bad || conflict)) ||
                     ((cmd.cmd_op == OP_CLEAR) && dst_bad));

    // ---------------- tables, guard counter, outputs ----------------
    always_comb begin
        shadow_en_d  = shadow_en_q;
        shadow_sel_d = shadow_sel_q;
        active_en_d  = active_en_q;
        active_sel_d = active_sel_q;
        err_d        = reject;
        cnt_d        = (state_q == ST_BREAK) ? cnt_q + CNT_W'(1) : '0;

        if (accept && !reject) begin
            case (cmd.cmd_op)
                OP_SET: begin
                    shadow_en_d[cmd.cmd_dst]  = 1'b1;
                    shadow_sel_d[cmd.cmd_dst] = cmd.cmd_src;
                end
                OP_CLEAR:     shadow_en_d[cmd.cmd_dst] = 1'b0;
                OP_CLEAR_ALL: shadow_en_d = '0;
                default:      ;
            endcase
        end

        if (state_q == ST_MAKE) begin
            active_en_d  = shadow_en_q;
            active_sel_d = shadow_sel_q;
        end

        // Enables come from the next active table so the new routing appears
        // right after MAKE; BREAK cycles keep every driver off.
        dst_oe_d = (state_q == ST_BREAK) ? '0 : active_en_d;
    end

    for (genvar gi = 0; gi < N_DST; gi++) begin : g_route
        assign dst_out_d[gi] = active_en_q[gi] & src_in[active_sel_q[gi]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            shadow_en_q <= '0;
            active_en_q <= '0;
            dst_out_q   <= '0;
            dst_oe_q    <= '0;
            err_q       <= 1'b0;
            for (int d = 0; d < N_DST; d++) begin
                shadow_sel_q[d] <= '0;
                active_sel_q[d] <= '0;
            end
        end else begin
            cnt_q        <= cnt_d;
            shadow_en_q  <= shadow_en_d;
            shadow_sel_q <= shadow_sel_d;
            active_en_q  <= active_en_d;
            active_sel_q <= active_sel_d;
            dst_out_q    <= dst_out_d;
            dst_oe_q     <= dst_oe_d;
            err_q        <= err_d;
        end
    end

    assign dst_out = dst_out_q;
    assign dst_oe  = dst_oe_q;
    assign err     = err_q;
endmodule

// File: tb/tb_pin_route_ctrl.sv
// Directed bench for pin_route_ctrl: vector table for command/err behaviour plus
// hand-written commit, back-pressure and mid-sequence reset sequences.
module tb_pin_route_ctrl;
    localparam int N_SRC = 36;
    localparam int N_DST = 21;
    localparam int GUARD = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_SRC-1:0] src_in;
    logic [N_DST-1:0] dst_out, dst_oe;
    logic             busy, err;

    pin_route_if #(.SEL_W(6), .DST_W(5)) cmd_if ();

    pin_route_ctrl #(
        .N_SRC(N_SRC), .N_DST(N_DST), .SEL_W(6), .DST_W(5), .GUARD_CYC(GUARD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_if), .src_in(src_in),
        .dst_out(dst_out), .dst_oe(dst_oe), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] op;
        logic [4:0] dst;
        logic [5:0] src;
        logic       exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] dst, input logic [5:0] src);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_dst   = dst;
        cmd_if.cmd_src   = src;
        tick();
        cmd_if.cmd_valid = 1'b0;
        $display("txn op=%0d dst=%0d src=%0d err=%0b", op, dst, src, err);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Sends COMMIT and samples cycles 1..12 after the accepting edge.
    task automatic commit_run(output int busy_n, output int zero_n, output int first_on);
        busy_n = 0; zero_n = 0; first_on = -1;
        send(2'd2, 5'd0, 6'd0);
        for (int k = 1; k <= 12; k++) begin
            if (busy) busy_n++;
            if (dst_oe == '0) zero_n++;
            else if (first_on < 0) first_on = k;
            tick();
        end
        $display("txn commit busy_cycles=%0d oe_zero_cycles=%0d first_on=%0d", busy_n, zero_n, first_on);
    endtask

    int b_n, z_n, f_on, wait_n;
    logic [N_DST-1:0] exp_mask;
    logic             exp_dst2;

    initial begin
        rst_n = 1'b0;
        src_in = '0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op = 2'd0;
        cmd_if.cmd_dst = '0;
        cmd_if.cmd_src = '0;

        // ---- reset state ----
        do_reset();
        chk("rst_dst_oe", 64'(dst_oe), 64'd0);
        chk("rst_dst_out", 64'(dst_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ready", 64'(cmd_if.cmd_ready), 64'd1);

        // ---- first route 3<-0: oe at GUARD+2, dst_out one cycle latency ----
        send(2'd0, 5'd3, 6'd0);
        commit_run(b_n, z_n, f_on);
        chk("first_busy_cycles", 64'(b_n), 64'(GUARD + 1));
        chk("first_oe_cycle", 64'(f_on), 64'(GUARD + 2));
        chk("first_oe_mask", 64'(dst_oe), 64'h8);
        src_in[0] = 1'b1; tick();
        chk("first_out_hi", 64'(dst_out[3]), 64'd1);
        src_in[0] = 1'b0; tick();
        chk("first_out_lo", 64'(dst_out[3]), 64'd0);

        // ---- reroute 3<-5: break window and busy length ----
        send(2'd0, 5'd3, 6'd5);
        commit_run(b_n, z_n, f_on);
        chk("reroute_oe_zero_cycles", 64'(z_n), 64'(GUARD));
        chk("reroute_busy_cycles", 64'(b_n), 64'(GUARD + 1));
        src_in = '0; src_in[5] = 1'b1; tick();
        chk("reroute_out_src5", 64'(dst_out[3]), 64'd1);
        src_in = '0; src_in[0] = 1'b1; tick();
        chk("reroute_out_src0", 64'(dst_out[3]), 64'd0);
        src_in = '0;

        // ---- command vector table ----
`ifdef PIN_ROUTE_CONFLICT_CHECK_EN
        exp_dst2 = 1'b0;
`else
        exp_dst2 = 1'b1;
`endif
        vecs[0] = '{op: 2'd0, dst: 5'd21, src: 6'd0,  exp_err: 1'b1};
        vecs[1] = '{op: 2'd0, dst: 5'd0,  src: 6'd36, exp_err: 1'b1};
        vecs[2] = '{op: 2'd1, dst: 5'd21, src: 6'd0,  exp_err: 1'b1};
        vecs[3] = '{op: 2'd0, dst: 5'd1,  src: 6'd7,  exp_err: 1'b0};
        vecs[4] = '{op: 2'd0, dst: 5'd2,  src: 6'd7,  exp_err: !exp_dst2};
        vecs[5] = '{op: 2'd0, dst: 5'd20, src: 6'd35, exp_err: 1'b0};
        vecs[6] = '{op: 2'd1, dst: 5'd20, src: 6'd0,  exp_err: 1'b0};
        vecs[7] = '{op: 2'd1, dst: 5'd3,  src: 6'd0,  exp_err: 1'b0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].op, vecs[i].dst, vecs[i].src);
            chk($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
        end
        tick();
        chk("err_single_pulse", 64'(err), 64'd0);
        commit_run(b_n, z_n, f_on);
        exp_mask = '0;
        exp_mask[1] = 1'b1;
        exp_mask[2] = exp_dst2;
        chk("table_oe_mask", 64'(dst_oe), 64'(exp_mask));
        src_in[7] = 1'b1; tick();
        chk("fanout_dst1", 64'(dst_out[1]), 64'd1);
        chk("fanout_dst2", 64'(dst_out[2]), 64'(exp_dst2));
        src_in = '0;

        // ---- command held during BREAK waits for IDLE ----
        send(2'd2, 5'd0, 6'd0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op = 2'd0;
        cmd_if.cmd_dst = 5'd4;
        cmd_if.cmd_src = 6'd9;
        wait_n = 0;
        while (cmd_if.cmd_ready == 1'b0 && wait_n < 20) begin
            wait_n++;
            tick();
        end
        chk("held_ready_low_cycles", 64'(wait_n), 64'(GUARD + 1));
        tick();
        cmd_if.cmd_valid = 1'b0;
        $display("txn held SET dst=4 src=9 waited=%0d err=%0b", wait_n, err);
        chk("held_err", 64'(err), 64'd0);
        commit_run(b_n, z_n, f_on);
        chk("held_applied_oe4", 64'(dst_oe[4]), 64'd1);

        // ---- reset in the second BREAK cycle ----
        send(2'd2, 5'd0, 6'd0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        $display("txn reset during BREAK");
        chk("abort_dst_oe", 64'(dst_oe), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(cmd_if.cmd_ready), 64'd1);
        src_in = '1;
        tick(); tick();
        chk("abort_active_empty_out", 64'(dst_out), 64'd0);
        chk("abort_active_empty_oe", 64'(dst_oe), 64'd0);
        src_in = '0;

        // ---- CLEAR_ALL wipes pending shadow entries ----
        send(2'd0, 5'd6, 6'd1);
        send(2'd3, 5'd0, 6'd0);
        chk("clear_all_err", 64'(err), 64'd0);
        commit_run(b_n, z_n, f_on);
        chk("clear_all_oe", 64'(dst_oe), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pin_route_ctrl.md
PIN_ROUTE_CTRL -- requirements
Module: pin_route_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 36: number of FPGA-side source pins.
REQ-002 SHALL have parameter N_DST, default 21: number of periphery-side destination pins.
REQ-003 SHALL have parameter SEL_W, default 6: width of the source index (2^SEL_W >= N_SRC).
REQ-004 SHALL have parameter DST_W, default 5: width of the destination index (2^DST_W >= N_DST).
REQ-005 SHALL have parameter GUARD_CYC, default 4: number of break-before-make guard cycles (>= 1).
REQ-006 SHALL have port clk, input, 1: the single clock, all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port cmd_valid, input, 1: command present.
REQ-009 SHALL have port cmd_ready, output, 1: command accepted when high together with cmd_valid.
REQ-010 SHALL have port cmd_op, input, 2: command code, 0=SET, 1=CLEAR, 2=COMMIT, 3=CLEAR_ALL.
REQ-011 SHALL have port cmd_dst, input, DST_W: destination index.
REQ-012 SHALL have port cmd_src, input, SEL_W: source index.
REQ-013 SHALL have port src_in, input, N_SRC: FPGA-side pin values.
REQ-014 SHALL have port dst_out, output, N_DST: routed periphery values.
REQ-015 SHALL have port dst_oe, output, N_DST: periphery output enables.
REQ-016 SHALL have port busy, output, 1: high while a commit sequence runs.
REQ-017 SHALL have port err, output, 1: one-cycle pulse flagging a rejected command.

Function
REQ-018 SHALL keep a shadow table and an active table, each holding an enable bit plus a SEL_W source index for every destination.
REQ-019 SHALL accept a command only on a cycle where cmd_valid=1 and cmd_ready=1.
REQ-020 SHALL drive cmd_ready=1 only in state IDLE.
REQ-021 SHALL handle SET by writing shadow[cmd_dst] = {en=1, sel=cmd_src}, leaving the active table unchanged.
REQ-022 SHALL handle CLEAR by setting shadow[cmd_dst].en = 0.
REQ-023 SHALL handle CLEAR_ALL by clearing every shadow enable in one cycle.
REQ-024 SHALL reject SET or CLEAR with cmd_dst >= N_DST, or SET with cmd_src >= N_SRC, by pulsing err the next cycle and leaving the tables unchanged.
REQ-025 SHALL run the state machine IDLE -> BREAK -> MAKE -> IDLE; an accepted COMMIT moves IDLE to BREAK.
REQ-026 SHALL, in BREAK, force dst_oe to all-zero for exactly GUARD_CYC cycles, then move to MAKE.
REQ-027 SHALL, in MAKE, copy the shadow table into the active table in one cycle and then return to IDLE.
REQ-028 SHALL hold busy=1 in BREAK and MAKE and busy=0 in IDLE.
REQ-029 SHALL, from the cycle after MAKE onward, register dst_oe[d] = active[d].en.
REQ-030 SHALL register dst_out[d] = active[d].en ? src_in[active[d].sel] : 0, with one clock of latency from src_in.
REQ-031 SHALL accept a COMMIT with an unchanged shadow table and still perform the full BREAK/MAKE sequence.
REQ-032 SHALL ignore cmd_op, cmd_dst and cmd_src whenever cmd_valid=0.

Reset
REQ-033 SHALL, on rst_n=0 at a rising edge, clear both tables, set state to IDLE and drive dst_out=0, dst_oe=0, busy=0, err=0 and cmd_ready=1 from the next cycle.
REQ-034 SHALL, on reset during BREAK or MAKE, abort the sequence and leave the active table cleared, never partially copied.

Configuration
REQ-035 SHALL support macro PIN_ROUTE_CONFLICT_CHECK_EN.
REQ-036 SHALL, with PIN_ROUTE_CONFLICT_CHECK_EN defined, reject a SET whose cmd_src is already enabled in the shadow table on a different destination (err pulse, no table change).
REQ-037 SHALL, without PIN_ROUTE_CONFLICT_CHECK_EN, allow fan-out: one source may drive any number of destinations.

Verification
REQ-038 SHALL cover: reset, then SET dst=3 src=0, COMMIT, src_in[0] toggling -> dst_oe[3]=1 after GUARD_CYC+2 cycles and dst_out[3] following src_in[0] one cycle later.
REQ-039 SHALL cover: active route 3<-0, SET dst=3 src=5, COMMIT -> dst_oe all-zero for exactly 4 cycles, busy=1 for 5 cycles, then dst_out[3] tracking src_in[5].
REQ-040 SHALL cover: SET dst=21 and SET dst=0 src=36 -> err pulses once each and tables are unchanged.
REQ-041 SHALL cover: cmd_valid held high during BREAK -> cmd_ready=0 and the command is accepted only on return to IDLE.
REQ-042 SHALL cover: with the macro defined, SET 1<-7 then SET 2<-7 -> second SET gives err=1; without the macro, after COMMIT both dst_out[1] and dst_out[2] follow src_in[7].
REQ-043 SHALL cover: rst_n=0 asserted in the second BREAK cycle -> next cycle dst_oe=0, busy=0, cmd_ready=1, and the active table is empty.
